// File: rtl/axi_gpio_ext.sv
// axi_gpio_ext: AXI-lite-style GPIO peripheral with a registered output port,
// synchronised inputs, per-bit rising-edge interrupt capture (W1C status) and
// a write-only print sink. Write (AW/W/B) and read (AR/R) paths run as two
// independent FSMs.

package utils_pkg;

   // Master-to-slave bus request bundle
   typedef struct packed {
      logic [7:0]  awid;
      logic [31:0] awaddr;
      logic        awvalid;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        wlast;
      logic        wvalid;
      logic        bready;
      logic [7:0]  arid;
      logic [31:0] araddr;
      logic        arvalid;
      logic        rready;
   } s_axi_mosi_t;

   // Slave-to-master bus response bundle
   typedef struct packed {
      logic        awready;
      logic        wready;
      logic [7:0]  bid;
      logic [1:0]  bresp;
      logic        bvalid;
      logic        arready;
      logic [7:0]  rid;
      logic [31:0] rdata;
      logic [1:0]  rresp;
      logic        rlast;
      logic        rvalid;
   } s_axi_miso_t;

endpackage

module axi_gpio_ext
   import utils_pkg::*;
#(
   parameter int              OUT_W       = 8,
   parameter int              IN_W        = 8,
   parameter logic [OUT_W-1:0] OUT_RST    = '0,
   parameter int              SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  s_axi_mosi_t       axi_mosi,
   output s_axi_miso_t       axi_miso,
   input  logic [IN_W-1:0]   gpio_i,
   output logic [OUT_W-1:0]  gpio_o,
   output logic              irq_o
);

   localparam logic [15:0] OFF_DATA_OUT   = 16'h0000;
   localparam logic [15:0] OFF_DATA_IN    = 16'h0004;
   localparam logic [15:0] OFF_PRINT      = 16'h0008;
   localparam logic [15:0] OFF_IRQ_EN     = 16'h000C;
   localparam logic [15:0] OFF_IRQ_STATUS = 16'h0010;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

   w_state_t          w_state, w_state_next;
   r_state_t          r_state, r_state_next;

   logic [15:0]       aw_addr_q;
   logic [7:0]        aw_id_q;
   logic [1:0]        bresp_q;

   logic [7:0]        rid_q;
   logic [31:0]       rdata_q;
   logic [1:0]        rresp_q;

   logic [OUT_W-1:0]  data_out;
   logic [IN_W-1:0]   irq_en;
   logic [IN_W-1:0]   irq_status;
   logic              irq_q;

   logic [IN_W-1:0]   sync_ff [SYNC_STAGES];
   logic [IN_W-1:0]   sync_in;
   logic [IN_W-1:0]   sync_prev;
   logic [IN_W-1:0]   rise;
   logic [IN_W-1:0]   status_clr;

   logic              aw_hs;
   logic              w_hs;
   logic              ar_hs;

   logic              wr_data_out;
   logic              wr_irq_en;
   logic              wr_irq_status;
   logic              wr_mapped;

   logic [31:0]       rd_val;
   logic              rd_mapped;

   logic              unused_bits;

   // Bus bits this block never looks at: upper address bits, byte strobes,
   // wlast (single-beat only) and wdata bits above the register widths.
   assign unused_bits = ^{axi_mosi.awaddr[31:16], axi_mosi.araddr[31:16],
                          axi_mosi.wstrb, axi_mosi.wlast, axi_mosi.wdata};

   assign aw_hs = (w_state == W_IDLE) && axi_mosi.awvalid;
   assign w_hs  = (w_state == W_DATA) && axi_mosi.wvalid;
   assign ar_hs = (r_state == R_IDLE) && axi_mosi.arvalid;

   assign sync_in = sync_ff[SYNC_STAGES-1];
   assign rise    = sync_in & ~sync_prev;

   // State registers for both bus FSMs; reset abandons any open transaction
   always_ff @(posedge clk) begin
      if (!rst) begin
         w_state <= W_IDLE;
         r_state <= R_IDLE;
      end else begin
         w_state <= w_state_next;
         r_state <= r_state_next;
      end
   end

   // Write FSM sequencing: address, then data, then hold the response until taken
   always_comb begin
      w_state_next = w_state;
      case (w_state)
         W_IDLE:  if (axi_mosi.awvalid) w_state_next = W_DATA;
         W_DATA:  if (axi_mosi.wvalid)  w_state_next = W_RESP;
         W_RESP:  if (axi_mosi.bready)  w_state_next = W_IDLE;
         default: w_state_next = W_IDLE;
      endcase
   end

   // Read FSM sequencing: capture on AR, hold R payload until the master takes it
   always_comb begin
      r_state_next = r_state;
      case (r_state)
         R_IDLE:  if (axi_mosi.arvalid) r_state_next = R_DATA;
         R_DATA:  if (axi_mosi.rready)  r_state_next = R_IDLE;
         default: r_state_next = R_IDLE;
      endcase
   end

   // Decode the latched write address; DATA_IN falls through as an error target
   always_comb begin
      wr_data_out   = 1'b0;
      wr_irq_en     = 1'b0;
      wr_irq_status = 1'b0;
      wr_mapped     = 1'b0;
      case (aw_addr_q)
         OFF_DATA_OUT: begin
            wr_mapped   = 1'b1;
            wr_data_out = w_hs;
         end
         OFF_PRINT: begin
            wr_mapped = 1'b1;
         end
         OFF_IRQ_EN: begin
            wr_mapped = 1'b1;
            wr_irq_en = w_hs;
         end
         OFF_IRQ_STATUS: begin
            wr_mapped     = 1'b1;
            wr_irq_status = w_hs;
         end
         default: begin
            wr_mapped = 1'b0;
         end
      endcase
   end

   // Read mux on the live AR address, zero-extending every register to 32 bits
   always_comb begin
      rd_val    = '0;
      rd_mapped = 1'b1;
      case (axi_mosi.araddr[15:0])
         OFF_DATA_OUT:   rd_val[OUT_W-1:0] = data_out;
         OFF_DATA_IN:    rd_val[IN_W-1:0]  = sync_in;
         OFF_PRINT:      rd_val            = '0;
         OFF_IRQ_EN:     rd_val[IN_W-1:0]  = irq_en;
         OFF_IRQ_STATUS: rd_val[IN_W-1:0]  = irq_status;
         default:        rd_mapped         = 1'b0;
      endcase
   end

   // Capture write address/id on AW and the write response on W
   always_ff @(posedge clk) begin
      if (!rst) begin
         aw_addr_q <= '0;
         aw_id_q   <= '0;
         bresp_q   <= RESP_OKAY;
      end else begin
         if (aw_hs) begin
            aw_addr_q <= axi_mosi.awaddr[15:0];
            aw_id_q   <= axi_mosi.awid;
         end
         if (w_hs) begin
            bresp_q <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

   // Snapshot read payload at the AR handshake so it stays stable under back-pressure
   always_ff @(posedge clk) begin
      if (!rst) begin
         rdata_q <= '0;
         rresp_q <= RESP_OKAY;
         rid_q   <= '0;
      end else if (ar_hs) begin
         rdata_q <= rd_val;
         rresp_q <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
         rid_q   <= axi_mosi.arid;
      end
   end

   // Output and enable registers, written at the W handshake
   always_ff @(posedge clk) begin
      if (!rst) begin
         data_out <= OUT_RST;
         irq_en   <= '0;
      end else begin
         if (wr_data_out) data_out <= axi_mosi.wdata[OUT_W-1:0];
         if (wr_irq_en)   irq_en   <= axi_mosi.wdata[IN_W-1:0];
      end
   end

   // Input synchroniser chain plus the previous-sample register for edge detection
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_ff[i] <= '0;
         sync_prev <= '0;
      end else begin
         sync_ff[0] <= gpio_i;
         for (int i = 1; i < SYNC_STAGES; i++) sync_ff[i] <= sync_ff[i-1];
         sync_prev <= sync_in;
      end
   end

   assign status_clr = wr_irq_status ? axi_mosi.wdata[IN_W-1:0] : '0;

   // Sticky edge status: W1C clears, but a same-cycle edge keeps the bit set
   always_ff @(posedge clk) begin
      if (!rst) begin
         irq_status <= '0;
      end else begin
         irq_status <= (irq_status & ~status_clr) | rise;
      end
   end

   // Interrupt line follows the committed status/enable one cycle later
   always_ff @(posedge clk) begin
      if (!rst) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= |(irq_status & irq_en);
      end
   end

   assign gpio_o = data_out;
   assign irq_o  = irq_q;

   // Bus response fields derived from FSM state and captured payloads
   always_comb begin
      axi_miso         = '0;
      axi_miso.awready = (w_state == W_IDLE);
      axi_miso.wready  = (w_state == W_DATA);
      axi_miso.bvalid  = (w_state == W_RESP);
      axi_miso.bid     = (w_state == W_RESP) ? aw_id_q : '0;
      axi_miso.bresp   = (w_state == W_RESP) ? bresp_q : RESP_OKAY;
      axi_miso.arready = (r_state == R_IDLE);
      axi_miso.rvalid  = (r_state == R_DATA);
      axi_miso.rlast   = (r_state == R_DATA);
      axi_miso.rid     = (r_state == R_DATA) ? rid_q : '0;
      axi_miso.rdata   = (r_state == R_DATA) ? rdata_q : '0;
      axi_miso.rresp   = (r_state == R_DATA) ? rresp_q : RESP_OKAY;
   end

endmodule
